// File: rtl/adc_serial_capture_if.sv
// Request/response bundle between test_adc and the ADC capture master.
// The master drives the request strobe; the capture block returns the sample.
interface adc_serial_capture_if #(
  parameter int DATA_W = 12
) ();
  logic              data_req;
  logic [DATA_W-1:0] data;
  logic              data_rdy;
  logic              busy;
  logic              overrun;

  modport master (
    output data_req,
    input  data,
    input  data_rdy,
    input  busy,
    input  overrun
  );

  modport slave (
    input  data_req,
    output data,
    output data_rdy,
    output busy,
    output overrun
  );
endinterface

// File: rtl/adc_serial_capture.sv
// Serial SAR ADC frame master: drives cs_n/sclk, shifts the frame in
// MSB first and returns the trailing DATA_W bits as a parallel word.
module adc_serial_capture #(
  parameter int DATA_W    = 12,
  parameter int LEAD_BITS = 4,
  parameter int CLK_DIV   = 2,
  parameter int CS_SETUP  = 2,
  parameter int QUIET_CYC = 4,
  parameter bit TWOS_COMP = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  adc_serial_capture_if.slave  cap,
  output logic                 adc_cs_n_o,
  output logic                 adc_sclk_o,
  input  logic                 adc_sdo_i
);

  localparam int NB   = LEAD_BITS + DATA_W;
  localparam int CM1  = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
  localparam int CMAX = (CM1 > QUIET_CYC) ? CM1 : QUIET_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(NB + 1);

  localparam logic [CW-1:0] CS_LAST  = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] Q_LAST   = CW'(QUIET_CYC - 1);
  localparam logic [BW-1:0] NB_LAST  = BW'(NB - 1);

  localparam logic [DATA_W-1:0] MSB_MASK =
    TWOS_COMP ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_QUIET = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [BW-1:0]     bit_q,   bit_d;
  logic [DATA_W-1:0] sh_q,    sh_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              pend_q,  pend_d;
  logic              rdy_q,   rdy_d;
  logic              ovr_q,   ovr_d;
  logic              busy_q,  busy_d;
  logic              cs_n_q,  cs_n_d;
  logic              sclk_q,  sclk_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    pend_d  = pend_q;
    rdy_d   = 1'b0;
    ovr_d   = 1'b0;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;

    case (state_q)
      S_IDLE: begin
        if (cap.data_req || pend_q) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          pend_d  = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_q == CS_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // sample on the edge that raises sclk
            sclk_d = 1'b1;
            sh_d   = {sh_q[DATA_W-2:0], adc_sdo_i};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == NB_LAST) begin
              state_d = S_DONE;
              cs_n_d  = 1'b1;
              rdy_d   = 1'b1;
              data_d  = sh_q ^ MSB_MASK;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_QUIET;
        cnt_d   = '0;
      end
      S_QUIET: begin
        if (cnt_q == Q_LAST) begin
          cnt_d = '0;
          // a queued request launches straight out of QUIET
          if (pend_q) begin
            state_d = S_SETUP;
            cs_n_d  = 1'b0;
            pend_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase

    if (cap.data_req && (state_q != S_IDLE)) begin
      if (pend_q) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      pend_q  <= 1'b0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
    end
  end

  assign cap.data     = data_q;
  assign cap.data_rdy = rdy_q;
  assign cap.busy     = busy_q;
  assign cap.overrun  = ovr_q;
  assign adc_cs_n_o   = cs_n_q;
  assign adc_sclk_o   = sclk_q;

endmodule
